// File: rtl/timer_pkg.sv
// Shared types for the timer bank: channel counting modes and the bit
// positions of the two sticky interrupt flags inside each channel's pair.
package timer_pkg;

   typedef enum logic [1:0] {
      MODE_UP   = 2'b00,
      MODE_DOWN = 2'b01,
      MODE_UPDN = 2'b10,
      MODE_HOLD = 2'b11
   } mode_e;

   localparam int IRQ_WRAP = 0;
   localparam int IRQ_CMP  = 1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, windowed up/down/centre-aligned counter,
// compare-match and wrap pulses, and sticky interrupt flags.
module timer_channel
   import timer_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int PSC_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  mode_e            mode_i,
   input  logic             oneshot_i,
   input  logic [PSC_W-1:0] psc_i,
   input  logic [CNT_W-1:0] min_i,
   input  logic [CNT_W-1:0] max_i,
   input  logic [CNT_W-1:0] cmp_i,
   input  logic [CNT_W-1:0] init_i,
   input  logic             load_i,
   input  logic [1:0]       irq_clr_i,
   output logic [CNT_W-1:0] value_o,
   output logic             wrap_o,
   output logic             match_o,
   output logic             dir_o,
   output logic             armed_o,
   output logic [1:0]       irq_sts_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1);

   logic [PSC_W-1:0] pscCnt_q, pscCnt_d;
   logic [CNT_W-1:0] value_q, value_d;
   logic             dir_q, dir_d;
   logic             armed_q;
   logic             wrap_q, match_q;
   logic [1:0]       irqSts_q;
   logic             tick, step, wrapHit, matchHit;

   always_comb begin
      tick     = (pscCnt_q == psc_i);
      step     = en_i & armed_q & tick & (mode_i != MODE_HOLD) & ~load_i;
      pscCnt_d = (!en_i || tick) ? '0 : pscCnt_q + PSC_ONE;
      value_d  = value_q;
      dir_d    = dir_q;
      wrapHit  = 1'b0;
      // A degenerate window pins the count and wraps on every step.
      if (min_i == max_i) begin
         value_d = min_i;
         wrapHit = 1'b1;
         if (mode_i == MODE_UP)
            dir_d = 1'b1;
         else if (mode_i == MODE_DOWN)
            dir_d = 1'b0;
      end else begin
         case (mode_i)
            MODE_UP: begin
               dir_d = 1'b1;
               if (value_q >= max_i) begin
                  value_d = min_i;
                  wrapHit = 1'b1;
               end else begin
                  value_d = value_q + CNT_ONE;
               end
            end
            MODE_DOWN: begin
               dir_d = 1'b0;
               if (value_q <= min_i) begin
                  value_d = max_i;
                  wrapHit = 1'b1;
               end else begin
                  value_d = value_q - CNT_ONE;
               end
            end
            MODE_UPDN: begin
               if (dir_q && value_q >= max_i) begin
                  dir_d   = 1'b0;
                  value_d = max_i - CNT_ONE;
               end else if (!dir_q && value_q <= min_i) begin
                  dir_d   = 1'b1;
                  value_d = min_i + CNT_ONE;
                  wrapHit = 1'b1;
               end else begin
                  value_d = dir_q ? value_q + CNT_ONE : value_q - CNT_ONE;
               end
            end
            default: begin
               value_d = value_q;
            end
         endcase
      end
      matchHit = step & (value_d == cmp_i);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pscCnt_q <= '0;
         value_q  <= '0;
         dir_q    <= 1'b1;
         armed_q  <= 1'b1;
         wrap_q   <= 1'b0;
         match_q  <= 1'b0;
         irqSts_q <= '0;
      end else begin
         wrap_q             <= step & wrapHit;
         match_q            <= matchHit;
         irqSts_q[IRQ_WRAP] <= (step & wrapHit) | (irqSts_q[IRQ_WRAP] & ~irq_clr_i[IRQ_WRAP]);
         irqSts_q[IRQ_CMP]  <= matchHit | (irqSts_q[IRQ_CMP] & ~irq_clr_i[IRQ_CMP]);
         if (load_i) begin
            value_q  <= init_i;
            pscCnt_q <= '0;
            armed_q  <= 1'b1;
         end else begin
            pscCnt_q <= pscCnt_d;
            if (step) begin
               value_q <= value_d;
               dir_q   <= dir_d;
               if (wrapHit && oneshot_i)
                  armed_q <= 1'b0;
            end
         end
      end
   end

   assign value_o   = value_q;
   assign wrap_o    = wrap_q;
   assign match_o   = match_q;
   assign dir_o     = dir_q;
   assign armed_o   = armed_q;
   assign irq_sts_o = irqSts_q;

endmodule

// File: rtl/timer_counter_bank.sv
// Bank of independent timer channels; slices the flat register-interface
// buses per channel and merges every sticky flag into one interrupt line.
module timer_counter_bank
   import timer_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = 16,
   parameter int PSC_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       en_i,
   input  logic [2*N_CH-1:0]     mode_i,
   input  logic [N_CH-1:0]       oneshot_i,
   input  logic [PSC_W*N_CH-1:0] psc_i,
   input  logic [CNT_W*N_CH-1:0] min_i,
   input  logic [CNT_W*N_CH-1:0] max_i,
   input  logic [CNT_W*N_CH-1:0] cmp_i,
   input  logic [CNT_W*N_CH-1:0] init_i,
   input  logic [N_CH-1:0]       load_i,
   input  logic [2*N_CH-1:0]     irq_clr_i,
   output logic [CNT_W*N_CH-1:0] value_o,
   output logic [N_CH-1:0]       wrap_o,
   output logic [N_CH-1:0]       match_o,
   output logic [N_CH-1:0]       dir_o,
   output logic [N_CH-1:0]       armed_o,
   output logic [2*N_CH-1:0]     irq_sts_o,
   output logic                  irq_o
);

   for (genvar k = 0; k < N_CH; k++) begin : gCh
      timer_channel #(
         .CNT_W (CNT_W),
         .PSC_W (PSC_W)
      ) uChannel (
         .clk       (clk),
         .rst       (rst),
         .en_i      (en_i[k]),
         .mode_i    (mode_e'(mode_i[2*k +: 2])),
         .oneshot_i (oneshot_i[k]),
         .psc_i     (psc_i[PSC_W*k +: PSC_W]),
         .min_i     (min_i[CNT_W*k +: CNT_W]),
         .max_i     (max_i[CNT_W*k +: CNT_W]),
         .cmp_i     (cmp_i[CNT_W*k +: CNT_W]),
         .init_i    (init_i[CNT_W*k +: CNT_W]),
         .load_i    (load_i[k]),
         .irq_clr_i (irq_clr_i[2*k +: 2]),
         .value_o   (value_o[CNT_W*k +: CNT_W]),
         .wrap_o    (wrap_o[k]),
         .match_o   (match_o[k]),
         .dir_o     (dir_o[k]),
         .armed_o   (armed_o[k]),
         .irq_sts_o (irq_sts_o[2*k +: 2])
      );
   end

   assign irq_o = |irq_sts_o;

endmodule

// File: tb/tb_timer_counter_bank.sv
// Bench for timer_counter_bank: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a reference model.
module tb_timer_counter_bank;

   localparam int N_CH  = 4;
   localparam int CNT_W = 16;
   localparam int PSC_W = 8;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [N_CH-1:0]       en = '0;
   logic [2*N_CH-1:0]     mode = '0;
   logic [N_CH-1:0]       oneshot = '0;
   logic [PSC_W*N_CH-1:0] psc = '0;
   logic [CNT_W*N_CH-1:0] minV = '0;
   logic [CNT_W*N_CH-1:0] maxV = '0;
   logic [CNT_W*N_CH-1:0] cmpV = '0;
   logic [CNT_W*N_CH-1:0] initV = '0;
   logic [N_CH-1:0]       load = '0;
   logic [2*N_CH-1:0]     irqClr = '0;
   logic [CNT_W*N_CH-1:0] value;
   logic [N_CH-1:0]       wrap, match, dir, armed;
   logic [2*N_CH-1:0]     irqSts;
   logic                  irq;

   int checks = 0;
   int errors = 0;

   logic [15:0] mValue [N_CH];
   int          mPhase [N_CH];
   bit          mDir   [N_CH];
   bit          mArmed [N_CH];
   bit          mWrap  [N_CH];
   bit          mMatch [N_CH];
   bit [1:0]    mSts   [N_CH];

   timer_counter_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .en_i      (en),
      .mode_i    (mode),
      .oneshot_i (oneshot),
      .psc_i     (psc),
      .min_i     (minV),
      .max_i     (maxV),
      .cmp_i     (cmpV),
      .init_i    (initV),
      .load_i    (load),
      .irq_clr_i (irqClr),
      .value_o   (value),
      .wrap_o    (wrap),
      .match_o   (match),
      .dir_o     (dir),
      .armed_o   (armed),
      .irq_sts_o (irqSts),
      .irq_o     (irq)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("[TB] FAIL %s ch%0d: got %0h, expected %0h at %0t", name, ch, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < N_CH; k++) begin
         mValue[k] = '0;
         mPhase[k] = 0;
         mDir[k]   = 1'b1;
         mArmed[k] = 1'b1;
         mWrap[k]  = 1'b0;
         mMatch[k] = 1'b0;
         mSts[k]   = 2'b00;
      end
   endtask

   // Advances every channel by one clock using the current input vectors.
   task automatic modelCycle();
      for (int k = 0; k < N_CH; k++) begin
         logic [15:0] v, mn, mx, cp, nv;
         logic [1:0]  md;
         bit          d, w, m, tick, chEn;
         int          p;
         v    = mValue[k];
         mn   = minV[16*k +: 16];
         mx   = maxV[16*k +: 16];
         cp   = cmpV[16*k +: 16];
         md   = mode[2*k +: 2];
         p    = int'(psc[8*k +: 8]);
         chEn = en[k];
         d    = mDir[k];
         w    = 1'b0;
         m    = 1'b0;
         nv   = v;
         if (load[k]) begin
            mValue[k] = initV[16*k +: 16];
            mPhase[k] = 0;
            mArmed[k] = 1'b1;
         end else begin
            tick = chEn && (mPhase[k] == p);
            mPhase[k] = (!chEn || tick) ? 0 : mPhase[k] + 1;
            if (chEn && mArmed[k] && tick && md != 2'b11) begin
               if (mn == mx) begin
                  nv = mn;
                  w  = 1'b1;
                  if (md == 2'b00) d = 1'b1;
                  if (md == 2'b01) d = 1'b0;
               end else if (md == 2'b00) begin
                  d = 1'b1;
                  if (v >= mx) begin nv = mn; w = 1'b1; end
                  else nv = v + 16'd1;
               end else if (md == 2'b01) begin
                  d = 1'b0;
                  if (v <= mn) begin nv = mx; w = 1'b1; end
                  else nv = v - 16'd1;
               end else begin
                  if (d && v >= mx) begin d = 1'b0; nv = mx - 16'd1; end
                  else if (!d && v <= mn) begin d = 1'b1; nv = mn + 16'd1; w = 1'b1; end
                  else nv = d ? v + 16'd1 : v - 16'd1;
               end
               m = (nv == cp);
               if (w && oneshot[k]) mArmed[k] = 1'b0;
               mValue[k] = nv;
               mDir[k]   = d;
            end
         end
         mWrap[k]  = w;
         mMatch[k] = m;
         mSts[k][0] = w | (mSts[k][0] & ~irqClr[2*k]);
         mSts[k][1] = m | (mSts[k][1] & ~irqClr[2*k+1]);
      end
   endtask

   task automatic compareAll();
      bit anySts;
      anySts = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         checkOutput("value", k, 32'(value[16*k +: 16]), 32'(mValue[k]));
         checkOutput("wrap", k, 32'(wrap[k]), 32'(mWrap[k]));
         checkOutput("match", k, 32'(match[k]), 32'(mMatch[k]));
         checkOutput("dir", k, 32'(dir[k]), 32'(mDir[k]));
         checkOutput("armed", k, 32'(armed[k]), 32'(mArmed[k]));
         checkOutput("irq_sts", k, 32'(irqSts[2*k +: 2]), 32'(mSts[k]));
         anySts |= (mSts[k] != 2'b00);
      end
      checkOutput("irq", -1, 32'(irq), 32'(anySts));
   endtask

   task automatic runCycle();
      @(posedge clk);
      modelCycle();
      #1;
      compareAll();
      @(negedge clk);
   endtask

   task automatic setCh(input int k, input logic [1:0] md, input bit os, input logic [7:0] ps,
                        input logic [15:0] mn, input logic [15:0] mx, input logic [15:0] cp, input logic [15:0] ini);
      mode[2*k +: 2]   = md;
      oneshot[k]       = os;
      psc[8*k +: 8]    = ps;
      minV[16*k +: 16] = mn;
      maxV[16*k +: 16] = mx;
      cmpV[16*k +: 16] = cp;
      initV[16*k +: 16] = ini;
   endtask

   task automatic pulseLoad(input int k);
      load[k] = 1'b1;
      runCycle();
      load[k] = 1'b0;
   endtask

   task automatic doReset();
      #2 rst = 1'b1;
      #1;
      modelReset();
      compareAll();
      checkOutput("async rst value", -1, 32'(value[31:0]), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic applyStimulus();
      load   = '0;
      irqClr = '0;
      for (int k = 0; k < N_CH; k++) begin
         if ($urandom_range(0, 31) == 0) load[k] = 1'b1;
         if ($urandom_range(0, 7) == 0) irqClr[2*k] = 1'b1;
         if ($urandom_range(0, 7) == 0) irqClr[2*k+1] = 1'b1;
         if ($urandom_range(0, 15) == 0) en[k] = ~en[k];
         if ($urandom_range(0, 63) == 0)
            setCh(k, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                  8'($urandom_range(0, 3)), 16'($urandom_range(0, 12)), 16'($urandom_range(0, 12)),
                  16'($urandom_range(0, 12)), 16'($urandom_range(0, 15)));
      end
   endtask

   initial begin
      int guard;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      compareAll();
      checkOutput("reset dir", -1, 32'(dir), 32'hF);
      checkOutput("reset armed", -1, 32'(armed), 32'hF);
      rst = 1'b0;

      // T1: UP 2..5 on ch0
      setCh(0, 2'b00, 1'b0, 8'd0, 16'd2, 16'd5, 16'd100, 16'd2);
      pulseLoad(0);
      checkOutput("T1 load", 0, 32'(value[15:0]), 32'd2);
      en[0] = 1'b1;
      runCycle(); checkOutput("T1 v3", 0, 32'(value[15:0]), 32'd3);
      runCycle(); checkOutput("T1 v4", 0, 32'(value[15:0]), 32'd4);
      runCycle(); checkOutput("T1 v5", 0, 32'(value[15:0]), 32'd5);
      runCycle(); checkOutput("T1 v2", 0, 32'(value[15:0]), 32'd2);
      checkOutput("T1 wrap", 0, 32'(wrap[0]), 32'd1);
      runCycle(); checkOutput("T1 v3b", 0, 32'(value[15:0]), 32'd3);
      checkOutput("T1 nowrap", 0, 32'(wrap[0]), 32'd0);

      // T2: DOWN psc=3 on ch1, enable gap restarts the prescale period
      setCh(1, 2'b01, 1'b0, 8'd3, 16'd0, 16'd9, 16'd100, 16'd5);
      pulseLoad(1);
      en[1] = 1'b1;
      repeat (3) runCycle();
      checkOutput("T2 wait", 1, 32'(value[31:16]), 32'd5);
      runCycle(); checkOutput("T2 step", 1, 32'(value[31:16]), 32'd4);
      repeat (2) runCycle();
      en[1] = 1'b0; runCycle(); en[1] = 1'b1;
      repeat (3) runCycle();
      checkOutput("T2 restart", 1, 32'(value[31:16]), 32'd4);
      runCycle(); checkOutput("T2 step2", 1, 32'(value[31:16]), 32'd3);
      en[1] = 1'b0;

      // T3: UPDN 0..3 on ch2 (dir still 1 from reset)
      setCh(2, 2'b10, 1'b0, 8'd0, 16'd0, 16'd3, 16'd100, 16'd0);
      pulseLoad(2);
      en[2] = 1'b1;
      for (int i = 0; i < 7; i++) begin
         logic [15:0] seq [7];
         seq = '{16'd1, 16'd2, 16'd3, 16'd2, 16'd1, 16'd0, 16'd1};
         runCycle();
         checkOutput("T3 value", 2, 32'(value[47:32]), 32'(seq[i]));
         checkOutput("T3 wrap", 2, 32'(wrap[2]), (i == 6) ? 32'd1 : 32'd0);
      end
      checkOutput("T3 dir", 2, 32'(dir[2]), 32'd1);
      en[2] = 1'b0;

      // T4: UP oneshot 0..2 on ch2
      setCh(2, 2'b00, 1'b1, 8'd0, 16'd0, 16'd2, 16'd100, 16'd0);
      pulseLoad(2);
      en[2] = 1'b1;
      repeat (3) runCycle();
      checkOutput("T4 wrapped", 2, 32'(value[47:32]), 32'd0);
      checkOutput("T4 disarmed", 2, 32'(armed[2]), 32'd0);
      repeat (2) runCycle();
      checkOutput("T4 hold", 2, 32'(value[47:32]), 32'd0);
      initV[47:32] = 16'd1;
      pulseLoad(2);
      checkOutput("T4 rearm", 2, 32'(armed[2]), 32'd1);
      runCycle(); checkOutput("T4 v2", 2, 32'(value[47:32]), 32'd2);
      runCycle(); checkOutput("T4 v0", 2, 32'(value[47:32]), 32'd0);
      checkOutput("T4 disarm2", 2, 32'(armed[2]), 32'd0);

      // T5: compare match and flag set-beats-clear on ch3
      setCh(3, 2'b00, 1'b0, 8'd0, 16'd0, 16'd7, 16'd4, 16'd0);
      pulseLoad(3);
      en[3] = 1'b1;
      repeat (4) runCycle();
      checkOutput("T5 match", 3, 32'(match[3]), 32'd1);
      checkOutput("T5 sts", 3, 32'(irqSts[7]), 32'd1);
      checkOutput("T5 irq", 3, 32'(irq), 32'd1);
      irqClr[7] = 1'b1; runCycle(); irqClr[7] = 1'b0;
      checkOutput("T5 cleared", 3, 32'(irqSts[7]), 32'd0);
      guard = 0;
      while (mValue[3] != 16'd3 && guard < 40) begin
         runCycle();
         guard++;
      end
      checkOutput("T5 reach", 3, 32'(guard < 40), 32'd1);
      irqClr[7] = 1'b1; runCycle(); irqClr[7] = 1'b0;
      checkOutput("T5 setwins", 3, 32'(irqSts[7]), 32'd1);

      // T6: asynchronous reset mid-count, then independent ch0/ch1 traffic
      repeat (3) runCycle();
      doReset();
      setCh(0, 2'b00, 1'b0, 8'd1, 16'd0, 16'd9, 16'd3, 16'd1);
      setCh(1, 2'b01, 1'b0, 8'd0, 16'd2, 16'd6, 16'd4, 16'd6);
      en = 4'b0011;
      load = 4'b0011; runCycle(); load = '0;
      repeat (5) runCycle();
      pulseLoad(1);
      repeat (8) runCycle();

      // Randomized traffic
      en = '1;
      for (int c = 0; c < 3000; c++) begin
         applyStimulus();
         runCycle();
         if (c == 1500) doReset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
